// File: rtl/camera_capture_v2.sv
// OV7670 capture front end: pairs camera bytes into RGB444 pixels, skips settling
// frames, and emits linear frame-buffer writes plus per-frame completion/error status.
module camera_capture_v2 #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int ADDR_W      = 19,
  parameter int SKIP_FRAMES = 2
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        data,
  input  logic              capture_en,
  input  logic [1:0]        mode,
  output logic              wr_en,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [11:0]       pix_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic [15:0]       frame_cnt,
  output logic              busy
);

  localparam logic [ADDR_W:0] TOTAL_L   = (ADDR_W+1)'(H_RES * V_RES);
  localparam logic [15:0]     H_L       = 16'(H_RES);
  localparam logic [15:0]     V_L       = 16'(V_RES);
  localparam logic [15:0]     SKIP_LAST = (SKIP_FRAMES > 0) ? 16'(SKIP_FRAMES - 1) : 16'd0;

  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_ARMED, S_CAPTURE} state_t;

  function automatic logic [11:0] to_rgb444(input logic [1:0] m, input logic [7:0] b0,
                                            input logic [7:0] b1);
    case (m)
      2'd1:    return {b0[3:0], b1[7:4], b1[3:0]};
      2'd2:    return {3{b0[7:4]}};
      default: return {b0[7:4], b0[2:0], b1[7], b1[4:1]};
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [15:0]       skip_cnt_q, skip_cnt_d;
  logic              vsync_q, href_q;
  logic              phase_q, phase_d;
  logic [7:0]        b0_q, b0_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic [15:0]       pix_cnt_q, pix_cnt_d;
  logic [15:0]       line_cnt_q, line_cnt_d;
  logic              err_q, err_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic [11:0]       pix_data_q, pix_data_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q, frame_err_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              pend_q, pend_d;
  logic              pend_err_q, pend_err_d;
  logic              vs_rise, vs_fall, fin_err;

  assign vs_rise = vsync & ~vsync_q;
  assign vs_fall = ~vsync & vsync_q;

  always_comb begin
    state_d      = state_q;
    skip_cnt_d   = skip_cnt_q;
    phase_d      = phase_q;
    b0_d         = b0_q;
    mode_d       = mode_q;
    addr_d       = addr_q;
    pix_cnt_d    = pix_cnt_q;
    line_cnt_d   = line_cnt_q;
    err_d        = err_q;
    wr_en_d      = 1'b0;
    pix_addr_d   = pix_addr_q;
    pix_data_d   = pix_data_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    pend_d       = 1'b0;
    pend_err_d   = pend_err_q;
    fin_err      = 1'b0;

    // A frame whose last pixel landed on the vsync-rise cycle reports one cycle later.
    if (pend_q) begin
      frame_done_d = 1'b1;
      frame_err_d  = pend_err_q;
      frame_cnt_d  = frame_cnt_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (capture_en && vs_rise) begin
          skip_cnt_d = 16'd0;
          state_d    = (SKIP_FRAMES > 0) ? S_SKIP : S_ARMED;
        end
      end
      S_SKIP: begin
        if (!capture_en) state_d = S_IDLE;
        else if (vs_rise) begin
          if (skip_cnt_q == SKIP_LAST) state_d = S_ARMED;
          else skip_cnt_d = skip_cnt_q + 16'd1;
        end
      end
      S_ARMED: begin
        if (vs_fall) begin
          state_d    = S_CAPTURE;
          mode_d     = (mode == 2'd3) ? 2'd0 : mode;
          addr_d     = '0;
          pix_cnt_d  = 16'd0;
          line_cnt_d = 16'd0;
          phase_d    = 1'b0;
          err_d      = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (href) begin
          if (!phase_q) begin
            b0_d    = data;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (addr_q < TOTAL_L && pix_cnt_q < H_L) begin
              wr_en_d    = 1'b1;
              pix_addr_d = addr_q[ADDR_W-1:0];
              pix_data_d = to_rgb444(mode_q, b0_q, data);
              addr_d     = addr_q + 1'b1;
              pix_cnt_d  = pix_cnt_q + 16'd1;
            end else begin
              err_d = 1'b1;
            end
          end
        end else begin
          phase_d = 1'b0;
          if (phase_q) err_d = 1'b1;
        end
        if (href_q && !href) begin
          if (pix_cnt_q != H_L) err_d = 1'b1;
          line_cnt_d = (line_cnt_q == 16'hFFFF) ? line_cnt_q : line_cnt_q + 16'd1;
          pix_cnt_d  = 16'd0;
        end
        if (vs_rise) begin
          phase_d = 1'b0;
          fin_err = err_d | (line_cnt_d != V_L);
          if (wr_en_d) begin
            pend_d     = 1'b1;
            pend_err_d = fin_err;
          end else begin
            frame_done_d = 1'b1;
            frame_err_d  = fin_err;
            frame_cnt_d  = frame_cnt_q + 16'd1;
          end
          state_d = capture_en ? S_ARMED : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      skip_cnt_q   <= 16'd0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      phase_q      <= 1'b0;
      b0_q         <= 8'd0;
      mode_q       <= 2'd0;
      addr_q       <= '0;
      pix_cnt_q    <= 16'd0;
      line_cnt_q   <= 16'd0;
      err_q        <= 1'b0;
      wr_en_q      <= 1'b0;
      pix_addr_q   <= '0;
      pix_data_q   <= 12'd0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_cnt_q  <= 16'd0;
      pend_q       <= 1'b0;
      pend_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      skip_cnt_q   <= skip_cnt_d;
      vsync_q      <= vsync;
      href_q       <= href;
      phase_q      <= phase_d;
      b0_q         <= b0_d;
      mode_q       <= mode_d;
      addr_q       <= addr_d;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      err_q        <= err_d;
      wr_en_q      <= wr_en_d;
      pix_addr_q   <= pix_addr_d;
      pix_data_q   <= pix_data_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      frame_cnt_q  <= frame_cnt_d;
      pend_q       <= pend_d;
      pend_err_q   <= pend_err_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign pix_addr   = pix_addr_q;
  assign pix_data   = pix_data_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = (state_q == S_SKIP) || (state_q == S_CAPTURE);

endmodule
